// File: rtl/kc_pkg.sv
// kc_pkg: shared types and constants for the synthetic keycode report path.
// Holds the game action enum, the raw keyboard codes for both players, the
// slot table geometry and small helpers used by the report generator.
package kc_pkg;

  localparam int NUM_SLOTS  = 4;
  localparam int SLOT_IDX_W = 2;

  typedef enum logic [2:0] {
    UP    = 3'd0,
    DOWN  = 3'd1,
    RIGHT = 3'd2,
    LEFT  = 3'd3,
    PUNCH = 3'd4,
    KICK  = 3'd5
  } action_t;

  // Player 1 raw codes
  localparam logic [7:0] P1_UP    = 8'h1A;
  localparam logic [7:0] P1_DOWN  = 8'h16;
  localparam logic [7:0] P1_RIGHT = 8'h07;
  localparam logic [7:0] P1_LEFT  = 8'h04;
  localparam logic [7:0] P1_PUNCH = 8'h0E;
  localparam logic [7:0] P1_KICK  = 8'h13;

  // Player 2 raw codes
  localparam logic [7:0] P2_UP    = 8'h52;
  localparam logic [7:0] P2_DOWN  = 8'h51;
  localparam logic [7:0] P2_RIGHT = 8'h4F;
  localparam logic [7:0] P2_LEFT  = 8'h50;
  localparam logic [7:0] P2_PUNCH = 8'h37;
  localparam logic [7:0] P2_KICK  = 8'h38;

  // One held-key entry; the hold timer lives beside it because its width is
  // a parameter of the top level.
  typedef struct packed {
    logic       valid;
    logic [7:0] code;
  } slot_t;

  // Byte a slot contributes to the report: empty slots read as 8'h00.
  function automatic logic [7:0] slot_report(input slot_t s);
    return s.valid ? s.code : 8'h00;
  endfunction

  // Lowest set bit index of a slot vector (0 when none is set).
  function automatic logic [SLOT_IDX_W-1:0] lowest_set(input logic [NUM_SLOTS-1:0] v);
    logic [SLOT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      idx = v[i] ? SLOT_IDX_W'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/kc_action_lut.sv
// kc_action_lut: maps (player, action) to the raw keyboard code that the
// action decoder recognises, plus a legal flag for action ids 6 and 7.
// Ports:
//   pno        in  1  0 = player 1, 1 = player 2
//   action_id  in  3  action_t encoding
//   code       out 8  raw code (8'h00 when illegal)
//   legal      out 1  action_id names a real action
module kc_action_lut
  import kc_pkg::*;
(
  input  logic       pno,
  input  logic [2:0] action_id,
  output logic [7:0] code,
  output logic       legal
);

  // Raw code table, inverse of the decoder's lookup
  always_comb begin
    code  = 8'h00;
    legal = 1'b0;
    case (action_t'(action_id))
      UP:      begin code = pno ? P2_UP    : P1_UP;    legal = 1'b1; end
      DOWN:    begin code = pno ? P2_DOWN  : P1_DOWN;  legal = 1'b1; end
      RIGHT:   begin code = pno ? P2_RIGHT : P1_RIGHT; legal = 1'b1; end
      LEFT:    begin code = pno ? P2_LEFT  : P1_LEFT;  legal = 1'b1; end
      PUNCH:   begin code = pno ? P2_PUNCH : P1_PUNCH; legal = 1'b1; end
      KICK:    begin code = pno ? P2_KICK  : P1_KICK;  legal = 1'b1; end
      default: begin code = 8'h00;                     legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/keycode_report_gen.sv
// keycode_report_gen: builds a 4-slot HID-style keycode report from player
// action events. Keeps a held-key table (lowest-free allocation, no
// compaction, auto-release after HOLD_FRAMES unrefreshed frames) and
// publishes a snapshot of it once per frame.
// Ports:
//   Clk, Reset_n   clock, asynchronous active-low reset
//   frame_tick     one-cycle pulse per video frame (snapshot + timer step)
//   clear          synchronous table flush; also blocks event acceptance
//   action_valid / action_ready   event handshake (ready = !clear)
//   action_pno, action_id, action_press   event payload
//   keycodes       registered report, slot i in bits [8i+7:8i]
//   report_valid   pulses with each keycodes update
//   overflow       sticky: a press was dropped because the table was full
module keycode_report_gen
  import kc_pkg::*;
#(
  parameter int HOLD_FRAMES = 8,
  parameter int TIMER_W     = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        clear,
  input  logic        action_valid,
  output logic        action_ready,
  input  logic        action_pno,
  input  logic [2:0]  action_id,
  input  logic        action_press,
  output logic [31:0] keycodes,
  output logic        report_valid,
  output logic        overflow
);

  localparam logic [TIMER_W-1:0] HOLD_T       = TIMER_W'(HOLD_FRAMES);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
  localparam bit                 AUTO_RELEASE = (HOLD_FRAMES != 0);

  slot_t                slot_r      [NUM_SLOTS];
  slot_t                slot_nxt_s  [NUM_SLOTS];
  logic [TIMER_W-1:0]   timer_r     [NUM_SLOTS];
  logic [TIMER_W-1:0]   timer_nxt_s [NUM_SLOTS];
  logic [31:0]          keycodes_r;
  logic                 report_valid_r;
  logic                 overflow_r;

  logic [7:0]           code_s;
  logic                 legal_s;
  logic                 accept_s;
  logic                 press_s;
  logic                 release_s;
  logic [NUM_SLOTS-1:0] match_vec_s;
  logic [NUM_SLOTS-1:0] free_vec_s;
  logic                 match_hit_s;
  logic                 free_hit_s;
  logic [SLOT_IDX_W-1:0] match_idx_s;
  logic [SLOT_IDX_W-1:0] free_idx_s;
  logic                 overflow_set_s;
  logic [31:0]          snap_s;

  kc_action_lut u_lut (
    .pno       (action_pno),
    .action_id (action_id),
    .code      (code_s),
    .legal     (legal_s)
  );

  assign action_ready = ~clear;
  assign accept_s     = action_valid & ~clear;
  assign press_s      = accept_s & legal_s & action_press;
  assign release_s    = accept_s & legal_s & ~action_press;

  // Match / free vectors and their priority encoders
  always_comb begin
    match_vec_s = '0;
    free_vec_s  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      match_vec_s[i] = slot_r[i].valid & (slot_r[i].code == code_s);
      free_vec_s[i]  = ~slot_r[i].valid;
    end
    match_hit_s = |match_vec_s;
    free_hit_s  = |free_vec_s;
    match_idx_s = lowest_set(match_vec_s);
    free_idx_s  = lowest_set(free_vec_s);
  end

  // A press that neither refreshes a held code nor finds a free slot is lost
  assign overflow_set_s = press_s & ~match_hit_s & ~free_hit_s;

  // Per-slot next state: clear > press/refresh > release > tick step
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_nxt_s[i]  = slot_r[i];
      timer_nxt_s[i] = timer_r[i];
      if (clear) begin
        slot_nxt_s[i].valid = 1'b0;
      end else if (press_s &&
                   ((match_hit_s && (match_idx_s == SLOT_IDX_W'(i))) ||
                    (!match_hit_s && free_hit_s && (free_idx_s == SLOT_IDX_W'(i))))) begin
        // Refresh keeps the code; allocation writes it. Either way no decrement.
        slot_nxt_s[i].valid = 1'b1;
        slot_nxt_s[i].code  = code_s;
        timer_nxt_s[i]      = HOLD_T;
      end else if (release_s && match_hit_s && (match_idx_s == SLOT_IDX_W'(i))) begin
        slot_nxt_s[i].valid = 1'b0;
      end else if (frame_tick && slot_r[i].valid && AUTO_RELEASE) begin
        timer_nxt_s[i]      = timer_r[i] - TIMER_ONE;
        slot_nxt_s[i].valid = (timer_r[i] != TIMER_ONE);
      end else begin
        slot_nxt_s[i]  = slot_r[i];
        timer_nxt_s[i] = timer_r[i];
      end
    end
  end

  // Report image of the table as currently registered
  always_comb begin
    snap_s = 32'h0000_0000;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      snap_s[8*i +: 8] = slot_report(slot_r[i]);
    end
  end

  // Slot table, report register and sticky overflow
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_r[i]  <= '0;
        timer_r[i] <= '0;
      end
      keycodes_r     <= 32'h0000_0000;
      report_valid_r <= 1'b0;
      overflow_r     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_r[i]  <= slot_nxt_s[i];
        timer_r[i] <= timer_nxt_s[i];
      end
      if (frame_tick) begin
        keycodes_r <= snap_s;
      end else begin
        keycodes_r <= keycodes_r;
      end
      report_valid_r <= frame_tick;
      overflow_r     <= overflow_r | overflow_set_s;
    end
  end

  assign keycodes     = keycodes_r;
  assign report_valid = report_valid_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_keycode_report_gen.sv
module tb_keycode_report_gen;

  localparam int HOLD = 3;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        clear = 1'b0;
  logic        action_valid = 1'b0;
  logic        action_pno = 1'b0;
  logic [2:0]  action_id = 3'd0;
  logic        action_press = 1'b0;
  logic        action_ready;
  logic [31:0] keycodes;
  logic        report_valid;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  keycode_report_gen #(.HOLD_FRAMES(HOLD), .TIMER_W(4)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .clear        (clear),
    .action_valid (action_valid),
    .action_ready (action_ready),
    .action_pno   (action_pno),
    .action_id    (action_id),
    .action_press (action_press),
    .keycodes     (keycodes),
    .report_valid (report_valid),
    .overflow     (overflow)
  );

  always #5 Clk = ~Clk;

  // Reference model: table of held keys, raw code list per player
  logic [7:0]  lut [12] = '{8'h1A, 8'h16, 8'h07, 8'h04, 8'h0E, 8'h13,
                            8'h52, 8'h51, 8'h4F, 8'h50, 8'h37, 8'h38};
  bit          mv [4];
  logic [7:0]  mc [4];
  int          mt [4];
  logic [31:0] exp_kc;
  bit          exp_rv;
  bit          exp_ovf;

  function automatic logic [31:0] model_pack();
    logic [31:0] w;
    w = 32'h0;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = mv[j] ? mc[j] : 8'h00;
    return w;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 4; j++) begin mv[j] = 1'b0; mc[j] = 8'h00; mt[j] = 0; end
    exp_kc = 32'h0; exp_rv = 1'b0; exp_ovf = 1'b0;
  endtask

  task automatic model_step();
    int touched;
    int hit;
    logic [7:0] code;
    touched = -1;
    exp_rv = frame_tick;
    if (frame_tick) exp_kc = model_pack();
    if (clear) begin
      for (int j = 0; j < 4; j++) mv[j] = 1'b0;
    end else begin
      if (action_valid && action_id < 3'd6) begin
        code = lut[int'(action_pno) * 6 + int'(action_id)];
        hit = -1;
        for (int j = 0; j < 4; j++) if (mv[j] && mc[j] == code) hit = j;
        if (action_press) begin
          if (hit >= 0) begin
            mt[hit] = HOLD; touched = hit;
          end else begin
            for (int j = 3; j >= 0; j--) if (!mv[j]) hit = j;
            if (hit >= 0) begin
              mv[hit] = 1'b1; mc[hit] = code; mt[hit] = HOLD; touched = hit;
            end else begin
              exp_ovf = 1'b1;
            end
          end
        end else if (hit >= 0) begin
          mv[hit] = 1'b0; touched = hit;
        end
      end
      if (frame_tick) begin
        for (int j = 0; j < 4; j++) begin
          if (j != touched && mv[j]) begin
            mt[j] = mt[j] - 1;
            if (mt[j] == 0) mv[j] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic drive(input bit v, input bit p, input int id, input bit pr,
                       input bit t, input bit c);
    action_valid = v; action_pno = p; action_id = 3'(id);
    action_press = pr; frame_tick = t; clear = c;
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic press(input bit p, input int id);
    drive(1, p, id, 1, 0, 0); cycle();
  endtask

  task automatic release_key(input bit p, input int id);
    drive(1, p, id, 0, 0, 0); cycle();
  endtask

  task automatic tick();
    drive(0, 0, 0, 0, 1, 0); cycle();
  endtask

  task automatic do_clear();
    drive(0, 0, 0, 0, 0, 1); cycle();
  endtask

  task automatic do_reset();
    @(posedge Clk); #3;
    Reset_n = 1'b0;
    model_reset();
    @(posedge Clk); #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (keycodes !== 32'h0) begin failures++; $display("FAIL reset_kc got=%h exp=%h", keycodes, 32'h0); end
    checks++; if (report_valid !== 1'b0) begin failures++; $display("FAIL reset_rv got=%b exp=0", report_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (action_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", action_ready); end
    model_reset();
    @(posedge Clk); #1; Reset_n = 1'b1;
    tick();
    checks++; if (keycodes !== 32'h0 || report_valid !== 1'b1) begin failures++; $display("FAIL reset_tick got=%h/%b exp=%h/1", keycodes, report_valid, 32'h0); end
    cycle();
    checks++; if (report_valid !== 1'b0) begin failures++; $display("FAIL rv_pulse got=%b exp=0", report_valid); end
  endtask

  task automatic test_press_report();
    press(0, 0);
    press(1, 4);
    tick();
    checks++; if (keycodes !== 32'h0000_371A) begin failures++; $display("FAIL press_report got=%h exp=%h", keycodes, 32'h0000_371A); end
    checks++; if (keycodes !== exp_kc) begin failures++; $display("FAIL press_model got=%h exp=%h", keycodes, exp_kc); end
  endtask

  task automatic test_release_reuse();
    release_key(0, 0);
    press(1, 2);
    tick();
    checks++; if (keycodes !== 32'h0000_374F) begin failures++; $display("FAIL slot_reuse got=%h exp=%h", keycodes, 32'h0000_374F); end
  endtask

  task automatic test_expiry();
    logic [31:0] want;
    do_clear();
    press(0, 4);
    for (int k = 1; k <= 5; k++) begin
      tick();
      want = (k <= HOLD) ? 32'h0000_000E : 32'h0;
      checks++; if (keycodes !== want) begin failures++; $display("FAIL expiry_r%0d got=%h exp=%h", k, keycodes, want); end
    end
    do_clear();
    press(0, 4);
    for (int k = 1; k <= 7; k++) begin
      if (k == 3) begin drive(1, 0, 4, 1, 1, 0); cycle(); end
      else tick();
      want = (k <= 6) ? 32'h0000_000E : 32'h0;
      checks++; if (keycodes !== want) begin failures++; $display("FAIL refresh_r%0d got=%h exp=%h", k, keycodes, want); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    press(0, 0); press(0, 1); press(0, 2); press(0, 3);
    press(0, 0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL dup_no_ovf got=%b exp=0", overflow); end
    press(0, 4);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    tick();
    checks++; if (keycodes !== 32'h0407_161A) begin failures++; $display("FAIL full_table got=%h exp=%h", keycodes, 32'h0407_161A); end
  endtask

  task automatic test_clear();
    drive(1, 0, 5, 1, 0, 1);
    #1;
    checks++; if (action_ready !== 1'b0) begin failures++; $display("FAIL clear_ready got=%b exp=0", action_ready); end
    cycle();
    checks++; if (keycodes !== 32'h0407_161A || overflow !== 1'b1) begin failures++; $display("FAIL clear_keeps got=%h/%b exp=%h/1", keycodes, overflow, 32'h0407_161A); end
    tick();
    checks++; if (keycodes !== 32'h0) begin failures++; $display("FAIL clear_empty got=%h exp=%h", keycodes, 32'h0); end
  endtask

  task automatic test_coincident();
    drive(1, 0, 5, 1, 1, 0); cycle();
    checks++; if (keycodes !== 32'h0 || report_valid !== 1'b1) begin failures++; $display("FAIL coinc_excl got=%h/%b exp=%h/1", keycodes, report_valid, 32'h0); end
    cycle();
    tick();
    checks++; if (keycodes !== 32'h0000_0013) begin failures++; $display("FAIL coinc_next got=%h exp=%h", keycodes, 32'h0000_0013); end
  endtask

  task automatic test_random();
    bit c;
    for (int n = 0; n < 800; n++) begin
      c = ($urandom_range(0, 40) == 0);
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
            $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0, c);
      #1;
      checks++; if (action_ready !== !c) begin failures++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, action_ready, !c); end
      cycle();
      checks++; if (keycodes !== exp_kc) begin failures++; $display("FAIL rnd_kc n=%0d got=%h exp=%h", n, keycodes, exp_kc); end
      checks++; if (report_valid !== exp_rv) begin failures++; $display("FAIL rnd_rv n=%0d got=%b exp=%b", n, report_valid, exp_rv); end
      checks++; if (overflow !== exp_ovf) begin failures++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, overflow, exp_ovf); end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    press(0, 0); press(0, 1); press(0, 2); press(0, 3); press(1, 0);
    tick();
    checks++; if (keycodes !== 32'h0407_161A || overflow !== 1'b1) begin failures++; $display("FAIL pre_reset got=%h/%b exp=%h/1", keycodes, overflow, 32'h0407_161A); end
    #3;
    Reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (keycodes !== 32'h0 || report_valid !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL async_reset got=%h/%b/%b exp=0/0/0", keycodes, report_valid, overflow); end
    @(posedge Clk); #1; Reset_n = 1'b1;
    tick();
    checks++; if (keycodes !== 32'h0 || report_valid !== 1'b1) begin failures++; $display("FAIL post_reset_tick got=%h/%b exp=%h/1", keycodes, report_valid, 32'h0); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press_report();
    test_release_reuse();
    test_expiry();
    test_overflow();
    test_clear();
    test_coincident();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
